// File: rtl/tdm_demux_1x4.sv
// Receive side of a 4-slot TDM link: words are gathered into slot registers, and each
// completed 4-word frame is presented on Y0..Y3 under a valid/ready handshake.
module tdm_demux_1x4 #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  input  logic         sync,
  output logic [N-1:0] Y0,
  output logic [N-1:0] Y1,
  output logic [N-1:0] Y2,
  output logic [N-1:0] Y3,
  output logic         frame_valid,
  input  logic         frame_ready,
  output logic [1:0]   slot,
  output logic         overflow
);

  localparam logic [1:0] SLOT_LAST = 2'd3;

  logic [N-1:0] a0, a1, a2;
  logic         complete;
  logic         out_free;

  // Handshake: a frame transfers on every cycle where frame_valid and frame_ready are
  // both 1. Y0..Y3 stay constant while frame_valid is 1. A finished frame can load in
  // the same cycle as a transfer. frame_ready is ignored while frame_valid is 0.
  assign complete = din_valid && !sync && (slot == SLOT_LAST);
  assign out_free = !frame_valid || frame_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      a0          <= '0;
      a1          <= '0;
      a2          <= '0;
      Y0          <= '0;
      Y1          <= '0;
      Y2          <= '0;
      Y3          <= '0;
      frame_valid <= 1'b0;
      slot        <= 2'd0;
      overflow    <= 1'b0;
    end else begin
      if (din_valid) begin
        if (sync) begin
          // Sync realigns to slot 0 and drops any partial frame.
          a0   <= din;
          slot <= 2'd1;
        end else begin
          case (slot)
            2'd0:    a0 <= din;
            2'd1:    a1 <= din;
            2'd2:    a2 <= din;
            default: ;
          endcase
          slot <= slot + 2'd1;
        end
      end

      if (complete && out_free) begin
        Y0          <= a0;
        Y1          <= a1;
        Y2          <= a2;
        Y3          <= din;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end

      if (complete && !out_free)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Bench for tdm_demux_1x4: vector table for slot and handshake timing, hand-written
// corner sequences, and a frame scoreboard that is popped on each transfer.
module tb_tdm_demux_1x4;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         sync = 1'b0;
  logic [N-1:0] Y0, Y1, Y2, Y3;
  logic         frame_valid;
  logic         frame_ready = 1'b0;
  logic [1:0]   slot;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  logic [4*N-1:0] exp_q[$];

  tdm_demux_1x4 #(.N(N)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .slot(slot), .overflow(overflow)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---- driver ----
  task automatic send(input logic [N-1:0] d, input logic sy);
    din       = d;
    din_valid = 1'b1;
    sync      = sy;
    tick();
    din_valid = 1'b0;
    sync      = 1'b0;
  endtask

  function automatic logic [4*N-1:0] frm(input int y0, input int y1, input int y2, input int y3);
    return {y3[N-1:0], y2[N-1:0], y1[N-1:0], y0[N-1:0]};
  endfunction

  // ---- scoreboard: every transfer must match the oldest expected frame ----
  always @(negedge clk) begin
    if (!rst && frame_valid && frame_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got frame %h expected none", {Y3, Y2, Y1, Y0});
      end else begin
        logic [4*N-1:0] e;
        e = exp_q.pop_front();
        if ({Y3, Y2, Y1, Y0} !== e) begin
          errors++;
          $display("FAIL sb_frame: got %h expected %h", {Y3, Y2, Y1, Y0}, e);
        end
      end
    end
  end

  typedef struct {
    logic           rst;
    logic           dv;
    logic           sy;
    logic [N-1:0]   d;
    logic           push;
    logic [4*N-1:0] f;
    logic [1:0]     e_slot;
    logic           e_fv;
    logic           e_ovf;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // Basic frame (ready held high), then resync mid-frame.
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 1, 0, 0, 1, 0, 0};
    vecs[2]  = '{0, 1, 0, 2, 0, 0, 2, 0, 0};
    vecs[3]  = '{0, 1, 0, 5, 0, 0, 3, 0, 0};
    vecs[4]  = '{0, 1, 0, 6, 1, frm(1, 2, 5, 6), 0, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{0, 1, 0, 1, 0, 0, 1, 0, 0};
    vecs[7]  = '{0, 1, 0, 2, 0, 0, 2, 0, 0};
    vecs[8]  = '{0, 1, 1, 5, 0, 0, 1, 0, 0};
    vecs[9]  = '{0, 1, 0, 6, 0, 0, 2, 0, 0};
    vecs[10] = '{0, 0, 1, 3, 0, 0, 2, 0, 0};
    vecs[11] = '{0, 1, 0, 7, 0, 0, 3, 0, 0};
    vecs[12] = '{0, 1, 0, 0, 1, frm(5, 6, 7, 0), 0, 1, 0};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{0, 1, 1, 4, 0, 0, 1, 0, 0};
    vecs[15] = '{1, 1, 0, 4, 0, 0, 0, 0, 0};

    frame_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].rst; din_valid = vecs[i].dv; sync = vecs[i].sy; din = vecs[i].d;
      if (vecs[i].push) exp_q.push_back(vecs[i].f);
      tick();
      check($sformatf("vec%0d_slot", i), slot, vecs[i].e_slot);
      check($sformatf("vec%0d_fv", i), frame_valid, vecs[i].e_fv);
      check($sformatf("vec%0d_ovf", i), overflow, vecs[i].e_ovf);
    end
    rst = 1'b0; din_valid = 1'b0; sync = 1'b0;

    // Gaps between words hold slot; frame still lands one cycle after the 4th word.
    begin
      int w[4] = '{1, 2, 5, 6};
      for (int i = 0; i < 4; i++) begin
        if (i == 3) exp_q.push_back(frm(1, 2, 5, 6));
        send(w[i][N-1:0], 1'b0);
        if (i < 3) begin
          for (int g = 0; g < 2; g++) begin
            tick();
            check("gap_slot", slot, i + 1);
            check("gap_fv", frame_valid, 0);
          end
        end
      end
      check("gap_fv_rise", frame_valid, 1);
      tick();
      check("gap_fv_fall", frame_valid, 0);
    end

    // Overflow: second frame dropped while the first is stalled.
    do_reset();
    frame_ready = 1'b0;
    exp_q.push_back(frm(1, 2, 5, 6));
    send(1, 0); send(2, 0); send(5, 0); send(6, 0);
    for (int i = 0; i < 4; i++) send(7, 0);
    check("ovf_set", overflow, 1);
    check("ovf_fv", frame_valid, 1);
    check("ovf_y", {Y3, Y2, Y1, Y0}, frm(1, 2, 5, 6));
    frame_ready = 1'b1;
    tick();
    check("ovf_fv_drop", frame_valid, 0);
    check("ovf_sticky", overflow, 1);
    tick();
    check("ovf_sticky2", overflow, 1);

    // Transfer and new load in the same cycle: no overflow, frame_valid stays high.
    do_reset();
    frame_ready = 1'b0;
    exp_q.push_back(frm(1, 2, 5, 6));
    send(1, 0); send(2, 0); send(5, 0); send(6, 0);
    send(4, 0); send(4, 0); send(4, 0);
    check("b2b_hold_y", {Y3, Y2, Y1, Y0}, frm(1, 2, 5, 6));
    frame_ready = 1'b1;
    exp_q.push_back(frm(4, 4, 4, 3));
    send(3, 0);
    check("b2b_fv", frame_valid, 1);
    check("b2b_ovf", overflow, 0);
    check("b2b_y", {Y3, Y2, Y1, Y0}, frm(4, 4, 4, 3));
    tick();
    check("b2b_fv_fall", frame_valid, 0);
    check("b2b_y_kept", {Y3, Y2, Y1, Y0}, frm(4, 4, 4, 3));

    // Reset mid-frame discards the partial frame and clears the outputs.
    send(1, 0); send(2, 0);
    check("rst_pre_slot", slot, 2);
    rst = 1'b1; din_valid = 1'b1; din = 3'd7;
    tick();
    rst = 1'b0; din_valid = 1'b0;
    check("rst_slot", slot, 0);
    check("rst_fv", frame_valid, 0);
    check("rst_y", {Y3, Y2, Y1, Y0}, 0);
    check("rst_ovf", overflow, 0);
    exp_q.push_back(frm(3, 1, 4, 2));
    send(3, 0); send(1, 0); send(4, 0); send(2, 0);
    check("rst_next_fv", frame_valid, 1);
    tick();
    check("rst_next_fall", frame_valid, 0);

    tick();
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
